// File: rtl/dcache_ld_arbiter_pkg.sv
// Shared types for the D$ load arbiter slice.
//   cfg_t     : core configuration (physical address width, data width)
//   lsu_op_e  : load operation encoding carried alongside each request
//   rr_pick   : round-robin selection of the first valid lane at/after a pointer
package dcache_ld_arbiter_pkg;

    typedef struct packed {
        int unsigned PLEN;
        int unsigned XLEN;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{PLEN: 32'd32, XLEN: 32'd32};

    typedef enum logic [3:0] {
        LD_B  = 4'd0,
        LD_BU = 4'd1,
        LD_H  = 4'd2,
        LD_HU = 4'd3,
        LD_W  = 4'd4,
        LD_WU = 4'd5,
        LD_D  = 4'd6
    } lsu_op_e;

    // Upper bound on lane count supported by rr_pick.
    localparam int unsigned MaxLanes = 32;

    // Returns the first lane index with valid set, scanning ptr, ptr+1, ...
    // modulo n. Returns ptr when nothing is valid. Scanning offsets from the
    // far end down lets the closest valid lane win without an early exit.
    function automatic int unsigned rr_pick(input logic [MaxLanes-1:0] valid,
                                            input int unsigned         ptr,
                                            input int unsigned         n);
        int unsigned idx;
        int unsigned off;
        rr_pick = ptr;
        for (int unsigned k = 0; k < MaxLanes; k++) begin
            if (k < n) begin
                off = n - 1 - k;
                idx = (ptr + off) % n;
                if (valid[idx]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/dcache_ld_arbiter_owner_fifo.sv
// Owner FIFO for outstanding D$ loads: records which lane issued each load
// so responses (returned in request order) can be routed back.
//   clk_i, rst_ni      : clock, async active-low reset
//   flush_kill_i       : mark every stored entry as killed this cycle
//   push_i/push_lane_i : enqueue an entry owned by push_lane_i
//   pop_i              : dequeue the head entry
//   head_lane_o        : owning lane of the head entry
//   head_killed_o      : head entry's response must be dropped
//   full_o, empty_o    : occupancy flags
module ld_owner_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned LANE_W = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_kill_i,
    input  logic              push_i,
    input  logic [LANE_W-1:0] push_lane_i,
    input  logic              pop_i,
    output logic [LANE_W-1:0] head_lane_o,
    output logic              head_killed_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [LANE_W-1:0] lane;
        logic              killed;
    } ld_owner_t;

    ld_owner_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o        = (count_q == CNT_W'(DEPTH));
    assign empty_o       = (count_q == '0);
    assign head_lane_o   = mem_q[rd_ptr_q].lane;
    assign head_killed_o = mem_q[rd_ptr_q].killed;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (flush_kill_i) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    mem_q[i].killed <= 1'b1;
                end
            end
            // A push coinciding with a kill is born killed.
            if (push_i) begin
                mem_q[wr_ptr_q] <= '{lane: push_lane_i, killed: flush_kill_i};
                wr_ptr_q        <= ptr_next(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop_i && !push_i) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

`ifndef SYNTHESIS
    a_no_overflow:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     !(push_i && full_o && !pop_i));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     !(pop_i && empty_o));
    a_count_range:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                     count_q <= CNT_W'(DEPTH));
`endif

endmodule

// File: rtl/dcache_ld_arbiter.sv
// Shares the single D$ load port among NUM_LANES LSU lanes.
// Round-robin grant on requests, in-order response routing via an owner
// FIFO, silent drain of responses orphaned by a pipeline flush. No added
// latency on either channel.
//   clk_i, rst_ni        : clock, async active-low reset
//   flush_i              : pipeline flush, kills all outstanding loads
//   lane_req_*           : per-lane load request channel (valid/ready/addr/op)
//   lane_rsp_*           : per-lane response channel (data/err broadcast)
//   dc_req_*             : D$ load request channel
//   dc_rsp_*             : D$ load response channel (in request order)
module dcache_ld_arbiter
    import dcache_ld_arbiter_pkg::*;
#(
    parameter cfg_t        Cfg             = EmptyCfg,
    parameter int unsigned NUM_LANES       = 2,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned LANE_W          = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 flush_i,
    input  logic    [NUM_LANES-1:0]              lane_req_valid_i,
    output logic    [NUM_LANES-1:0]              lane_req_ready_o,
    input  logic    [NUM_LANES-1:0][Cfg.PLEN-1:0] lane_req_addr_i,
    input  lsu_op_e [NUM_LANES-1:0]              lane_req_op_i,
    output logic    [NUM_LANES-1:0]              lane_rsp_valid_o,
    input  logic    [NUM_LANES-1:0]              lane_rsp_ready_i,
    output logic    [NUM_LANES-1:0][Cfg.XLEN-1:0] lane_rsp_data_o,
    output logic    [NUM_LANES-1:0]              lane_rsp_err_o,
    output logic                                 dc_req_valid_o,
    input  logic                                 dc_req_ready_i,
    output logic    [Cfg.PLEN-1:0]               dc_req_addr_o,
    output lsu_op_e                              dc_req_op_o,
    input  logic                                 dc_rsp_valid_i,
    output logic                                 dc_rsp_ready_o,
    input  logic    [Cfg.XLEN-1:0]               dc_rsp_data_i,
    input  logic                                 dc_rsp_err_i
);

    logic [LANE_W-1:0] rr_ptr_q;
    logic [LANE_W-1:0] pick;
    logic              can_issue;
    logic              req_hs;
    logic              rsp_pop;
    logic [LANE_W-1:0] head_lane;
    logic              head_killed;
    logic              fifo_full;
    logic              fifo_empty;

    // Issue only depends on flush and FIFO occupancy, never on this cycle's
    // response pop, so there is no combinational rsp->req path.
    assign can_issue      = !flush_i && !fifo_full;
    assign pick           = LANE_W'(rr_pick(MaxLanes'(lane_req_valid_i),
                                            32'(rr_ptr_q), NUM_LANES));
    assign dc_req_valid_o = can_issue && (|lane_req_valid_i);
    assign dc_req_addr_o  = lane_req_addr_i[pick];
    assign dc_req_op_o    = lane_req_op_i[pick];
    assign req_hs         = dc_req_valid_o && dc_req_ready_i;

    always_comb begin
        lane_req_ready_o = '0;
        if (req_hs) lane_req_ready_o[pick] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (req_hs) begin
            rr_ptr_q <= (pick == LANE_W'(NUM_LANES - 1)) ? '0 : pick + LANE_W'(1);
        end
    end

    // During a flush the head is treated as killed as well, so a response
    // landing in the flush cycle is consumed and dropped like any other
    // orphan instead of stalling behind a lane that no longer wants it.
    always_comb begin
        lane_rsp_valid_o = '0;
        dc_rsp_ready_o   = 1'b0;
        if (!fifo_empty) begin
            if (head_killed || flush_i) begin
                dc_rsp_ready_o = 1'b1;
            end else begin
                dc_rsp_ready_o              = lane_rsp_ready_i[head_lane];
                lane_rsp_valid_o[head_lane] = dc_rsp_valid_i;
            end
        end
    end

    assign rsp_pop = dc_rsp_valid_i && dc_rsp_ready_o;

    always_comb begin
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            lane_rsp_data_o[i] = dc_rsp_data_i;
            lane_rsp_err_o[i]  = dc_rsp_err_i;
        end
    end

    ld_owner_fifo #(
        .DEPTH  (MAX_OUTSTANDING),
        .LANE_W (LANE_W)
    ) u_owner_fifo (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_kill_i  (flush_i),
        .push_i        (req_hs),
        .push_lane_i   (pick),
        .pop_i         (rsp_pop),
        .head_lane_o   (head_lane),
        .head_killed_o (head_killed),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty)
    );

`ifndef SYNTHESIS
    a_rsp_without_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                          dc_rsp_valid_i |-> !fifo_empty);
`endif

endmodule

// File: tb/tb_dcache_ld_arbiter.sv
module tb_dcache_ld_arbiter;
    import dcache_ld_arbiter_pkg::*;

    logic                  clk_i;
    logic                  rst_ni;
    logic                  flush_i;
    logic    [1:0]         lane_req_valid_i;
    logic    [1:0]         lane_req_ready_o;
    logic    [1:0][31:0]   lane_req_addr_i;
    lsu_op_e [1:0]         lane_req_op_i;
    logic    [1:0]         lane_rsp_valid_o;
    logic    [1:0]         lane_rsp_ready_i;
    logic    [1:0][31:0]   lane_rsp_data_o;
    logic    [1:0]         lane_rsp_err_o;
    logic                  dc_req_valid_o;
    logic                  dc_req_ready_i;
    logic    [31:0]        dc_req_addr_o;
    lsu_op_e               dc_req_op_o;
    logic                  dc_rsp_valid_i;
    logic                  dc_rsp_ready_o;
    logic    [31:0]        dc_rsp_data_i;
    logic                  dc_rsp_err_i;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    dcache_ld_arbiter #(
        .Cfg             (EmptyCfg),
        .NUM_LANES       (2),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .lane_req_valid_i (lane_req_valid_i),
        .lane_req_ready_o (lane_req_ready_o),
        .lane_req_addr_i  (lane_req_addr_i),
        .lane_req_op_i    (lane_req_op_i),
        .lane_rsp_valid_o (lane_rsp_valid_o),
        .lane_rsp_ready_i (lane_rsp_ready_i),
        .lane_rsp_data_o  (lane_rsp_data_o),
        .lane_rsp_err_o   (lane_rsp_err_o),
        .dc_req_valid_o   (dc_req_valid_o),
        .dc_req_ready_i   (dc_req_ready_i),
        .dc_req_addr_o    (dc_req_addr_o),
        .dc_req_op_o      (dc_req_op_o),
        .dc_rsp_valid_i   (dc_rsp_valid_i),
        .dc_rsp_ready_o   (dc_rsp_ready_o),
        .dc_rsp_data_i    (dc_rsp_data_i),
        .dc_rsp_err_i     (dc_rsp_err_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_ni           = 1'b0;
        flush_i          = 1'b0;
        lane_req_valid_i = 2'b00;
        lane_req_addr_i  = '0;
        lane_req_op_i    = {LD_B, LD_B};
        lane_rsp_ready_i = 2'b00;
        dc_req_ready_i   = 1'b0;
        dc_rsp_valid_i   = 1'b0;
        dc_rsp_data_i    = '0;
        dc_rsp_err_i     = 1'b0;

        // Reset state
        #3;
        check("rst_dc_req_valid", 64'(dc_req_valid_o), 64'd0);
        check("rst_lane_req_rdy", 64'(lane_req_ready_o), 64'd0);
        check("rst_dc_rsp_ready", 64'(dc_rsp_ready_o), 64'd0);
        check("rst_lane_rsp_vld", 64'(lane_rsp_valid_o), 64'd0);
        check("rst_dc_req_addr",  64'(dc_req_addr_o), 64'd0);
        check("rst_rsp_data",     64'(lane_rsp_data_o), 64'd0);
        step(); step();
        rst_ni = 1'b1;
        step();

        // Both lanes request: lane0 then lane1, then stall at 2 outstanding
        lane_req_valid_i   = 2'b11;
        lane_req_addr_i[0] = 32'h100;
        lane_req_addr_i[1] = 32'h200;
        lane_req_op_i[0]   = LD_W;
        lane_req_op_i[1]   = LD_H;
        dc_req_ready_i     = 1'b1;
        #1;
        check("a1_dc_req_valid", 64'(dc_req_valid_o), 64'd1);
        check("a1_addr", 64'(dc_req_addr_o), 64'h100);
        check("a1_op", 64'(dc_req_op_o), 64'(LD_W));
        check("a1_grant", 64'(lane_req_ready_o), 64'b01);
        step();
        lane_req_valid_i = 2'b10;
        #1;
        check("a2_addr", 64'(dc_req_addr_o), 64'h200);
        check("a2_op", 64'(dc_req_op_o), 64'(LD_H));
        check("a2_grant", 64'(lane_req_ready_o), 64'b10);
        step();
        // Full: issue blocked; live head lane0 but lane not ready
        lane_req_valid_i   = 2'b11;
        lane_req_addr_i[0] = 32'h104;
        dc_rsp_valid_i     = 1'b1;
        dc_rsp_data_i      = 32'hAAAA;
        lane_rsp_ready_i   = 2'b00;
        #1;
        check("a3_full_stall", 64'(dc_req_valid_o), 64'd0);
        check("a3_no_grant", 64'(lane_req_ready_o), 64'd0);
        check("a3_rsp_valid", 64'(lane_rsp_valid_o), 64'b01);
        check("a3_backpressure", 64'(dc_rsp_ready_o), 64'd0);
        step();
        lane_rsp_ready_i = 2'b01;
        #1;
        check("a4_rsp_valid", 64'(lane_rsp_valid_o), 64'b01);
        check("a4_dc_rsp_ready", 64'(dc_rsp_ready_o), 64'd1);
        check("a4_rsp_data0", 64'(lane_rsp_data_o[0]), 64'hAAAA);
        check("a4_still_full", 64'(dc_req_valid_o), 64'd0);
        step();
        // count=1: pop lane1's response while pushing a new lane0 load
        dc_rsp_data_i    = 32'hBBBB;
        lane_rsp_ready_i = 2'b10;
        #1;
        check("a5_rsp_valid", 64'(lane_rsp_valid_o), 64'b10);
        check("a5_rsp_data1", 64'(lane_rsp_data_o[1]), 64'hBBBB);
        check("a5_dc_rsp_ready", 64'(dc_rsp_ready_o), 64'd1);
        check("a5_grant", 64'(lane_req_ready_o), 64'b01);
        check("a5_addr", 64'(dc_req_addr_o), 64'h104);
        step();
        // Still count=1, so exactly one more issue fits
        dc_rsp_valid_i     = 1'b0;
        lane_req_valid_i   = 2'b10;
        lane_req_addr_i[1] = 32'h204;
        #1;
        check("a6_grant", 64'(lane_req_ready_o), 64'b10);
        step();
        lane_req_valid_i = 2'b11;
        dc_rsp_valid_i   = 1'b1;
        dc_rsp_data_i    = 32'hCCCC;
        lane_rsp_ready_i = 2'b11;
        #1;
        check("a7_full_stall", 64'(dc_req_valid_o), 64'd0);
        check("a7_rsp_valid", 64'(lane_rsp_valid_o), 64'b01);
        step();
        lane_req_valid_i = 2'b00;
        dc_rsp_data_i    = 32'hDDDD;
        #1;
        check("a8_rsp_valid", 64'(lane_rsp_valid_o), 64'b10);
        step();
        dc_rsp_valid_i = 1'b0;
        #1;
        check("a9_empty_rsp_ready", 64'(dc_rsp_ready_o), 64'd0);
        check("a9_empty_rsp_valid", 64'(lane_rsp_valid_o), 64'd0);

        // D$ not ready: no grant, rr pointer holds at 0
        dc_req_ready_i   = 1'b0;
        lane_req_valid_i = 2'b10;
        #1;
        check("b1_req_valid", 64'(dc_req_valid_o), 64'd1);
        check("b1_no_grant", 64'(lane_req_ready_o), 64'd0);
        check("b1_addr", 64'(dc_req_addr_o), 64'h204);
        step();
        lane_req_valid_i = 2'b11;
        #1;
        check("b2_rr_hold_addr", 64'(dc_req_addr_o), 64'h104);
        step();
        // Lane1 alone with rr_ptr=0 is granted; pointer wraps to 0
        dc_req_ready_i   = 1'b1;
        lane_req_valid_i = 2'b10;
        #1;
        check("b3_grant_lane1", 64'(lane_req_ready_o), 64'b10);
        step();
        lane_req_valid_i = 2'b11;
        #1;
        check("b4_rr_wrap", 64'(lane_req_ready_o), 64'b01);
        check("b4_addr", 64'(dc_req_addr_o), 64'h104);
        step();

        // Flush with two outstanding: both responses drained silently
        flush_i = 1'b1;
        #1;
        check("c1_flush_block", 64'(dc_req_valid_o), 64'd0);
        check("c1_flush_grant", 64'(lane_req_ready_o), 64'd0);
        step();
        flush_i          = 1'b0;
        lane_req_valid_i = 2'b00;
        dc_rsp_valid_i   = 1'b1;
        dc_rsp_data_i    = 32'hEEEE;
        lane_rsp_ready_i = 2'b00;
        #1;
        check("c2_killed_valid", 64'(lane_rsp_valid_o), 64'd0);
        check("c2_killed_ready", 64'(dc_rsp_ready_o), 64'd1);
        step();
        dc_rsp_data_i = 32'hFFFF;
        #1;
        check("c3_killed_valid", 64'(lane_rsp_valid_o), 64'd0);
        check("c3_killed_ready", 64'(dc_rsp_ready_o), 64'd1);
        step();
        // Drained to empty; rr_ptr=1 from before the flush
        dc_rsp_valid_i   = 1'b0;
        lane_req_valid_i = 2'b11;
        #1;
        check("c4_empty_ready", 64'(dc_rsp_ready_o), 64'd0);
        check("c4_grant", 64'(lane_req_ready_o), 64'b10);
        step();
        #1;
        check("c5_grant", 64'(lane_req_ready_o), 64'b01);
        step();
        #1;
        check("c6_full_stall", 64'(dc_req_valid_o), 64'd0);
        step();
        // Response arriving in the flush cycle is dropped
        lane_req_valid_i = 2'b00;
        flush_i          = 1'b1;
        dc_rsp_valid_i   = 1'b1;
        dc_rsp_data_i    = 32'h1234;
        lane_rsp_ready_i = 2'b11;
        #1;
        check("c7_flush_rsp_valid", 64'(lane_rsp_valid_o), 64'd0);
        check("c7_flush_rsp_ready", 64'(dc_rsp_ready_o), 64'd1);
        step();
        flush_i       = 1'b0;
        dc_rsp_data_i = 32'h5678;
        #1;
        check("c8_killed_valid", 64'(lane_rsp_valid_o), 64'd0);
        check("c8_killed_ready", 64'(dc_rsp_ready_o), 64'd1);
        step();
        dc_rsp_valid_i   = 1'b0;
        lane_req_valid_i = 2'b11;
        #1;
        check("c9_empty_ready", 64'(dc_rsp_ready_o), 64'd0);
        check("c9_rr_after_flush", 64'(lane_req_ready_o), 64'b10);
        step();
        #1;
        check("d1_grant", 64'(lane_req_ready_o), 64'b01);
        step();

        // Async reset mid-operation clears FIFO and rr pointer at once
        lane_req_valid_i = 2'b00;
        rst_ni           = 1'b0;
        #1;
        check("d2_rst_rsp_ready", 64'(dc_rsp_ready_o), 64'd0);
        check("d2_rst_grant", 64'(lane_req_ready_o), 64'd0);
        #1;
        rst_ni = 1'b1;
        step();
        lane_req_valid_i = 2'b11;
        #1;
        check("d3_rr_reset", 64'(lane_req_ready_o), 64'b01);
        check("d3_empty_ready", 64'(dc_rsp_ready_o), 64'd0);
        step();
        lane_req_valid_i = 2'b00;
        dc_req_ready_i   = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
